ballot_collector: RTL and testbench
===================================

# ballot_collector

Upstream stage of the voting path. Opens a ballot window on `start` and captures each enabled voter's first vote as it arrives. When every enabled voter has voted, or the window times out, it hands a frozen 8-bit ballot to the fail-counting voter stage over a valid/ready handshake. Voters that do not vote before the deadline are recorded as fail (1), so a silent voter can never mask a fault.

## Interface
- `N_VOTERS`, 8, number of voter lanes (the voter stage consumes 8).
- `TIMEOUT_W`, 8, width of the timeout counter.

- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  open a ballot window; honoured only in IDLE.
- `num_voters`  in  4  enabled voter count; sampled on accepted `start`; values >8 clamp to 8.
- `timeout_cycles`  in  TIMEOUT_W  window length minus one; sampled on accepted `start`.
- `vote_strb`  in  N_VOTERS  per-voter vote strobe.
- `vote_val`  in  N_VOTERS  per-voter vote; 0 = safe, 1 = fail; qualified by `vote_strb[i]`.
- `ballot_ready`  in  1  downstream accepts the ballot.
- `ballot_valid`  out  1  ballot available; held until accepted.
- `ballot`  out  N_VOTERS  captured votes; bits ≥ num_voters are 0.
- `received`  out  N_VOTERS  voters that actually voted in this window.
- `timed_out`  out  1  window ended by deadline with at least one enabled voter missing.
- `busy`  out  1  state ≠ IDLE.

## Operation
- The block has three states: IDLE, COLLECT and PRESENT.
- **IDLE.** On `start`:
  - clear `ballot`, `received` and `timed_out`;
  - latch the clamped `num_voters` into `nv`;
  - build the enable mask `en[i] = (i < nv)`;
  - load the timer with `timeout_cycles`;
  - go to COLLECT.
- **COLLECT.** Each cycle, for every i with `en[i] & vote_strb[i] & ~received[i]`:
  - set `ballot[i] = vote_val[i]` and `received[i] = 1`;
  - the first vote wins, and later strobes from the same voter are ignored;
  - strobes on disabled lanes are ignored.
- **COLLECT exit:**
  - Complete when `(received | capture_now) & en == en`. Go to PRESENT with `timed_out = 0`.
  - Otherwise, if timer == 0: set `ballot[i] = 1` for every enabled voter that has not voted, set `timed_out = 1`, and go to PRESENT.
  - Otherwise decrement the timer.
  - A vote strobed in the expiry cycle is captured normally. It counts toward completion, so `timed_out` is only set if some voter is still missing.
  - `nv = 0`: complete in the first COLLECT cycle; ballot is all-zero.
- **PRESENT.** `ballot_valid = 1`, and `ballot`, `received` and `timed_out` are stable. On `ballot_ready` go to IDLE.
- `start` is ignored in COLLECT and PRESENT. There is no queuing.
- Reset in any state returns to IDLE with all outputs 0. A partially collected ballot is discarded.

## Timing
- Reset values: `ballot_valid = 0`, `ballot = 0`, `received = 0`, `timed_out = 0`, `busy = 0`, timer = 0.
- `start` sampled high at edge E. COLLECT begins after E, and `busy` is high from E onward. Strobes are sampled at edges E+1 onward.
- All enabled votes present at edge E+k: `ballot_valid` rises after E+k, a latency of 1 cycle from the completing edge.
- Timeout: the window spans exactly `timeout_cycles + 1` sampling edges. With `timeout_cycles = T` and no votes, `ballot_valid` rises after edge E+T+1.
- Handshake: transfer occurs at an edge with `ballot_valid & ballot_ready`. `ballot_valid` falls after that edge and `busy` falls with it.
- Earliest next `start` is accepted at the transfer edge + 1. Minimum cycle is 3 edges per ballot.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `ballot_pkg`:
  - `state_t` enum {IDLE, COLLECT, PRESENT};
  - `N_VOTERS_MAX = 8`;
  - vote polarity constants `VOTE_SAFE = 0` and `VOTE_FAIL = 1`.
- Sub-module `ballot_timer`: a loadable TIMEOUT_W down-counter with `load`, `en` and a registered `zero` flag.
- The FSM and capture registers stay in `ballot_collector`.

## Test plan
- `nv = 5`, T = 20; voters 0–4 strobe values 1,0,1,0,0 at separate cycles -> `ballot = 8'b0000_0101`, `received = 8'h1F`, `timed_out = 0`, `ballot_valid` one cycle after the last strobe.
- `nv = 3`, T = 4; only voter 1 strobes 0 -> after 5 sampling edges `ballot = 8'b0000_0101`, `received = 8'h02`, `timed_out = 1`.
- `nv = 2`, T = 0; voter 0 and voter 1 strobe 0 in the single window cycle -> `ballot = 0`, `received = 8'h03`, `timed_out = 0`.
- Voter 2 strobes 1 then 0; voter 6 strobes with `nv = 4` -> `ballot[2] = 1`, `ballot[6] = 0`, `received[6] = 0`.
- `ballot_ready` held low for 10 cycles, with `start` pulsed during PRESENT -> ballot stable, `start` ignored; after the ready edge, IDLE with `busy = 0`. `nv = 0` -> all-zero ballot one cycle after COLLECT entry. `num_voters = 12` -> treated as 8.
- `rst` pulsed mid-COLLECT with 2 votes captured -> all outputs 0 immediately (async); the next `start` yields a fresh ballot with no stale bits.

Source files
------------

// File: rtl/ballot_pkg.sv
// ballot_pkg: shared state encoding and vote constants for the ballot collection path.
package ballot_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;
  localparam int N_VOTERS_MAX = 8;
  localparam logic VOTE_SAFE = 1'b0;
  localparam logic VOTE_FAIL = 1'b1;
endpackage

// File: rtl/ballot_timer.sv
// ballot_timer: loadable down-counter with registered zero flag; ports clk, rst, load, d (load value), en (decrement), zero.
module ballot_timer #(
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] d,
  input  logic                 en,
  output logic                 zero
);
  logic [TIMEOUT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else if (load) begin
      cnt  <= d;
      zero <= d == '0;
    end else if (en && cnt != '0) begin
      cnt  <= cnt - 1'b1;
      zero <= cnt == TIMEOUT_W'(1);
    end
endmodule

// File: rtl/ballot_collector.sv
// ballot_collector: collects first votes of enabled voters in a timed window and presents a frozen ballot.
// Ports: clk, rst (async high), start, num_voters, timeout_cycles, vote_strb, vote_val, ballot_ready;
// outputs ballot_valid, ballot, received, timed_out, busy.
module ballot_collector
  import ballot_pkg::*;
#(
  parameter int N_VOTERS  = 8,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           num_voters,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [N_VOTERS-1:0]  vote_strb,
  input  logic [N_VOTERS-1:0]  vote_val,
  input  logic                 ballot_ready,
  output logic                 ballot_valid,
  output logic [N_VOTERS-1:0]  ballot,
  output logic [N_VOTERS-1:0]  received,
  output logic                 timed_out,
  output logic                 busy
);
  state_t state, state_n;
  logic [N_VOTERS-1:0] en_mask, start_mask, capture, missing;
  logic complete, zero, expire_now, accept;
  // i < num_voters over lanes 0..N-1 clamps counts above N to all lanes
  always_comb begin
    start_mask = '0;
    for (int i = 0; i < N_VOTERS; i++) start_mask[i] = i < int'(num_voters);
  end
  assign accept     = state == IDLE && start;
  assign capture    = en_mask & vote_strb & ~received;
  assign missing    = en_mask & ~(received | capture);
  assign complete   = missing == '0;
  assign expire_now = !complete && zero;
  ballot_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .d   (timeout_cycles),
    .en  (state == COLLECT),
    .zero(zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE    ? (start ? COLLECT : IDLE) :
              state == COLLECT ? ((complete || zero) ? PRESENT : COLLECT) :
                                 (ballot_ready ? IDLE : PRESENT);
  always_comb begin
    ballot_valid = state == PRESENT;
    busy         = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en_mask   <= '0;
      ballot    <= '0;
      received  <= '0;
      timed_out <= 1'b0;
    end else if (accept) begin
      en_mask   <= start_mask;
      ballot    <= '0;
      received  <= '0;
      timed_out <= 1'b0;
    end else if (state == COLLECT) begin
      ballot    <= (ballot & ~capture) | (vote_val & capture) |
                   (expire_now ? missing & {N_VOTERS{VOTE_FAIL}} : '0);
      received  <= received | capture;
      timed_out <= expire_now;
    end
endmodule

// File: tb/tb_ballot_collector.sv
// tb_ballot_collector: directed scoreboard bench for ballot_collector.
module tb_ballot_collector;
  logic clk = 0, rst = 1, start = 0, ballot_ready = 0;
  logic [3:0] num_voters = 0;
  logic [7:0] timeout_cycles = 0, vote_strb = 0, vote_val = 0;
  logic ballot_valid, timed_out, busy;
  logic [7:0] ballot, received;
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] b; logic [7:0] r; logic t;} exp_t;
  exp_t q[$];
  logic [7:0] held;

  ballot_collector dut (
    .clk(clk), .rst(rst), .start(start), .num_voters(num_voters),
    .timeout_cycles(timeout_cycles), .vote_strb(vote_strb), .vote_val(vote_val),
    .ballot_ready(ballot_ready), .ballot_valid(ballot_valid), .ballot(ballot),
    .received(received), .timed_out(timed_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] nv, input logic [7:0] t);
    @(negedge clk);
    start = 1; num_voters = nv; timeout_cycles = t;
    @(negedge clk);
    start = 0;
  endtask

  task automatic strobe(input logic [7:0] s, input logic [7:0] v);
    vote_strb = s; vote_val = v;
    @(negedge clk);
    vote_strb = 0; vote_val = 0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!ballot_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, ballot_valid, 1);
  endtask

  task automatic take(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, q.size() != 0, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check({tag, "_ballot"}, ballot, e.b);
      check({tag, "_received"}, received, e.r);
      check({tag, "_timed_out"}, timed_out, e.t);
    end
    ballot_ready = 1;
    @(negedge clk);
    ballot_ready = 0;
    check({tag, "_valid_low"}, ballot_valid, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    #1;
    check("rst_valid", ballot_valid, 0);
    check("rst_ballot", ballot, 0);
    check("rst_received", received, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;

    // five voters, all vote at separate cycles
    do_start(5, 20);
    check("t1_busy", busy, 1);
    q.push_back('{8'h05, 8'h1F, 1'b0});
    strobe(8'h01, 8'h01); @(negedge clk);
    strobe(8'h02, 8'h00); @(negedge clk);
    strobe(8'h04, 8'h04); @(negedge clk);
    strobe(8'h08, 8'h00);
    check("t1_not_yet", ballot_valid, 0);
    strobe(8'h10, 8'h00);
    check("t1_latency", ballot_valid, 1);
    take("t1");

    // timeout with voters 0 and 2 silent
    do_start(3, 4);
    q.push_back('{8'h05, 8'h02, 1'b1});
    strobe(8'h02, 8'h00);
    repeat (3) @(negedge clk);
    check("t2_early", ballot_valid, 0);
    @(negedge clk);
    check("t2_deadline", ballot_valid, 1);
    take("t2");

    // zero timeout, both votes land in the single window cycle
    do_start(2, 0);
    q.push_back('{8'h00, 8'h03, 1'b0});
    strobe(8'h03, 8'h00);
    check("t3_valid", ballot_valid, 1);
    take("t3");

    // first vote wins, disabled lane ignored
    do_start(4, 10);
    q.push_back('{8'h04, 8'h0F, 1'b0});
    strobe(8'h44, 8'h44);
    strobe(8'h04, 8'h00);
    strobe(8'h0B, 8'h00);
    wait_valid("t4", 5);
    take("t4");

    // backpressure with start pulsed during PRESENT
    do_start(1, 5);
    q.push_back('{8'h01, 8'h01, 1'b0});
    strobe(8'h01, 8'h01);
    held = ballot;
    for (int i = 0; i < 10; i++) begin
      start = i == 4;
      @(negedge clk);
    end
    start = 0;
    check("t5_held_valid", ballot_valid, 1);
    check("t5_held_ballot", ballot, held);
    take("t5");
    @(negedge clk);
    check("t5_no_queued_start", busy, 0);

    // no enabled voters
    do_start(0, 7);
    q.push_back('{8'h00, 8'h00, 1'b0});
    @(negedge clk);
    check("t6_valid", ballot_valid, 1);
    take("t6");

    // count above 8 clamps to 8, all silent
    do_start(12, 3);
    q.push_back('{8'hFF, 8'h00, 1'b1});
    wait_valid("t7", 8);
    take("t7");

    // async reset mid-collect discards partial ballot
    do_start(4, 10);
    strobe(8'h03, 8'h03);
    #2 rst = 1;
    #1;
    check("t8_busy", busy, 0);
    check("t8_ballot", ballot, 0);
    check("t8_received", received, 0);
    check("t8_valid", ballot_valid, 0);
    @(negedge clk);
    rst = 0;
    do_start(2, 1);
    q.push_back('{8'h01, 8'h02, 1'b1});
    strobe(8'h02, 8'h00);
    wait_valid("t8b", 5);
    take("t8b");

    check("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
